// File: rtl/sequencer.sv
// sequencer: multi-cycle control FSM driving datapath strobes for an accumulator CPU.
module sequencer #(
    parameter int OP_W = 3
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    input  logic            run,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            CS,
    output logic            R_NW,
    output logic            halted
);
    typedef enum logic [3:0] {
        IDLE, FETCH_A, FETCH_M, DECODE, ADDR, MEM, WR, EXEC, HALT
    } state_t;
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);
    state_t state, next;
    logic mem_op, is_store, jump, is_halt;
    assign is_store = op == OP_STORE;
    assign mem_op   = op == OP_LOAD || is_store || op == OP_ADD || op == OP_SUB;
    assign jump     = op == OP_JMP || (op == OP_BNE && !z_flag);
    assign is_halt  = op == OP_HALT;
    always_ff @(posedge clock or negedge n_reset)
        if (!n_reset) state <= IDLE;
        else state <= next;
    always_comb begin
        next = IDLE;
        case (state)
            IDLE:    next = FETCH_A;
            FETCH_A: next = FETCH_M;
            FETCH_M: next = mem_ready ? DECODE : FETCH_M;
            DECODE:  next = ADDR;
            ADDR:    next = mem_op ? MEM : is_halt ? HALT : FETCH_A;
            MEM:     next = is_store ? WR : mem_ready ? EXEC : MEM;
            WR:      next = mem_ready ? FETCH_A : WR;
            EXEC:    next = FETCH_A;
            HALT:    next = run ? FETCH_A : HALT;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        {ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR,
         MDR_bus, load_MDR, ALU_ACC, ALU_add, ALU_sub, CS, halted} = '0;
        R_NW = 1'b1;
        case (state)
            FETCH_A: begin
                PC_bus   = 1'b1;
                load_MAR = 1'b1;
                INC_PC   = 1'b1;
                load_PC  = 1'b1;
            end
            FETCH_M: begin
                CS       = 1'b1;
                load_MDR = mem_ready;
            end
            DECODE: begin
                MDR_bus = 1'b1;
                load_IR = 1'b1;
            end
            ADDR: begin
                Addr_bus = mem_op || jump;
                load_MAR = mem_op;
                load_PC  = jump;
            end
            // STORE stages the accumulator into MDR; other memory ops read it in
            MEM: begin
                ACC_bus  = is_store;
                load_MDR = is_store || mem_ready;
                CS       = !is_store;
            end
            WR: begin
                CS   = 1'b1;
                R_NW = 1'b0;
            end
            EXEC: begin
                MDR_bus  = 1'b1;
                load_ACC = 1'b1;
                ALU_add  = op == OP_ADD;
                ALU_sub  = op == OP_SUB;
                ALU_ACC  = op == OP_ADD || op == OP_SUB;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 SHALL have parameter OP_W, default 3, width of the opcode field.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 n_reset  input  1  asynchronous, active-low reset.
REQ-004 op  input  OP_W  opcode from the instruction register (000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 BNE, 101 JMP, 110 NOP, 111 HALT).
REQ-005 z_flag  input  1  accumulator-zero flag.
REQ-006 mem_ready  input  1  memory access completes in the cycle it is sampled high.
REQ-007 run  input  1  resume request out of HALT.
REQ-008 outputs, each 1 bit: ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, MDR_bus, load_MDR, ALU_ACC, ALU_add, ALU_sub, CS, R_NW, halted.

Function
REQ-009 SHALL be a registered-state FSM with states IDLE, FETCH_A, FETCH_M, DECODE, ADDR, MEM, WR, EXEC, HALT; outputs are decoded from the state plus op/z_flag/mem_ready only.
REQ-010 Every output not listed for a state SHALL be 0, except R_NW, which SHALL default to 1.
REQ-011 IDLE: no outputs asserted; -> FETCH_A unconditionally.
REQ-012 FETCH_A: PC_bus, load_MAR, INC_PC, load_PC; -> FETCH_M.
REQ-013 FETCH_M: CS, R_NW=1; load_MDR only when mem_ready=1; stays in FETCH_M while mem_ready=0; -> DECODE when mem_ready=1.
REQ-014 DECODE: MDR_bus, load_IR; -> ADDR.
REQ-015 ADDR, op LOAD/STORE/ADD/SUB: Addr_bus, load_MAR; -> MEM.
REQ-016 ADDR, op JMP, or op BNE with z_flag=0: Addr_bus, load_PC; -> FETCH_A.
REQ-017 ADDR, op NOP, or op BNE with z_flag=1: no outputs; -> FETCH_A.
REQ-018 ADDR, op HALT: no outputs; -> HALT.
REQ-019 MEM, op STORE: ACC_bus, load_MDR; -> WR.
REQ-020 MEM, op LOAD/ADD/SUB: CS, R_NW=1; load_MDR only when mem_ready=1; holds while mem_ready=0; -> EXEC when mem_ready=1.
REQ-021 WR: CS, R_NW=0; holds while mem_ready=0; -> FETCH_A when mem_ready=1.
REQ-022 EXEC: MDR_bus, load_ACC; for ADD, ALU_ACC and ALU_add; for SUB, ALU_ACC and ALU_sub; for LOAD, ALU_ACC=0; -> FETCH_A.
REQ-023 HALT: halted=1, no other outputs asserted; -> FETCH_A when run=1, otherwise stays.
REQ-024 Latency with mem_ready tied high SHALL be: JMP/BNE/NOP 4 cycles; LOAD/ADD/SUB/STORE 6 cycles. Each mem_ready=0 cycle in FETCH_M, MEM or WR SHALL add exactly one cycle.
REQ-025 ALU_add and ALU_sub SHALL never both be 1; load_IR and load_ACC SHALL never both be 1.
REQ-026 CS SHALL be 1 only in FETCH_M, MEM (non-STORE) and WR.
REQ-027 run SHALL be ignored in every state except HALT.
REQ-028 Unreachable state encodings SHALL go to IDLE on the next clock.

Reset
REQ-029 n_reset=0 SHALL force state IDLE immediately, regardless of the clock, including mid-access in FETCH_M, MEM or WR.
REQ-030 While n_reset=0 and in IDLE, all outputs SHALL be 0 except R_NW=1; halted=0.
REQ-031 The first rising clock edge after n_reset deasserts SHALL move IDLE -> FETCH_A.

Verification
REQ-032 Reset, release, mem_ready=1, op=110 -> state sequence IDLE, FETCH_A, FETCH_M, DECODE, ADDR, FETCH_A; INC_PC high for exactly one cycle per instruction.
REQ-033 op=010, mem_ready=1 -> EXEC drives MDR_bus=1, load_ACC=1, ALU_ACC=1, ALU_add=1, ALU_sub=0; instruction takes 6 cycles. Repeat with op=011: ALU_sub=1, ALU_add=0.
REQ-034 op=001 with mem_ready=0 for 3 cycles in WR -> CS=1 and R_NW=0 for 4 cycles, then FETCH_A.
REQ-035 op=100: z_flag=0 -> load_PC=1 and Addr_bus=1 in ADDR; z_flag=1 -> no load_PC in ADDR; both cases next state FETCH_A.
REQ-036 op=111 -> halted=1 and stays 1 for 10 cycles with run=0; run=1 for one cycle -> FETCH_A with halted=0.
REQ-037 n_reset pulsed low while in MEM with mem_ready=0 -> CS=0 and R_NW=1 immediately; after release the sequence restarts at IDLE then FETCH_A.
